vita49_pkt_framer: RTL and testbench



---
 rtl/vita49_pkt_framer.sv | 179 +++++++++++++++++
 tb/tb_vita49_pkt_framer.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vita49_pkt_framer.sv
// vita49_pkt_framer
//   Wraps a 32-bit I/Q AXI-Stream into VRT IF-Data-with-Stream-ID packets.
//   Each packet has five prologue words followed by len payload words:
//   header, stream ID, TSI, TSF[63:32], TSF[31:0], then the samples.
//   The timestamp is the tsi/tsf value present on the edge where the first
//   sample of the packet is first presented (s_tvalid=1 while idle).
//
// Ports
//   samp_clk, ARESET        sample clock, async active-high reset
//   enable                  start new packets while high
//   stream_id, payload_len  latched at packet start
//   tsi, tsf                timestamp counters (samp_clk domain)
//   s_tdata/s_tvalid/s_tready           sample input stream
//   m_tdata/m_tvalid/m_tready/m_tlast   packet output stream
//   busy                    high whenever a packet is in progress
//   pkt_done                one-cycle pulse after the last word transfers
module vita49_pkt_framer #(
  parameter int unsigned HDR_WORDS   = 5,
  parameter int unsigned MAX_PAYLOAD = 65530
) (
  input  logic        samp_clk,
  input  logic        ARESET,
  input  logic        enable,
  input  logic [31:0] stream_id,
  input  logic [15:0] payload_len,
  input  logic [31:0] tsi,
  input  logic [63:0] tsf,
  input  logic [31:0] s_tdata,
  input  logic        s_tvalid,
  output logic        s_tready,
  output logic [31:0] m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tlast,
  output logic        busy,
  output logic        pkt_done
);

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StSid,
    StTsi,
    StTsfHi,
    StTsfLo,
    StPayload
  } state_e;

  state_e      state_q;
  logic [3:0]  pkt_count_q;
  logic [31:0] sid_q;
  logic [31:0] tsi_q;
  logic [63:0] tsf_q;
  logic [15:0] len_q;
  logic [15:0] cnt_q;
  logic [31:0] word_q;       // registered prologue word
  logic        word_valid_q; // registered prologue valid
  logic        pkt_done_q;

  logic [15:0] len_clamped;
  logic [15:0] pkt_size;
  logic [31:0] hdr_word;
  logic        is_payload;
  logic        last_word;

  // Zero-length requests become one word; oversize requests are clamped so the
  // 16-bit packet size field (prologue + payload) cannot overflow.
  always_comb begin
    len_clamped = payload_len;
    if (payload_len == 16'd0) begin
      len_clamped = 16'd1;
    end else if (payload_len > 16'(MAX_PAYLOAD)) begin
      len_clamped = 16'(MAX_PAYLOAD);
    end
  end

  assign pkt_size = 16'(HDR_WORDS) + len_clamped;

  // Type 1 (IF data with stream ID), no class ID, no trailer,
  // TSI = UTC, TSF = sample count.
  assign hdr_word = {4'b0001, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, pkt_count_q, pkt_size};

  assign is_payload = (state_q == StPayload);
  assign last_word  = (cnt_q == len_q - 16'd1);

  always_ff @(posedge samp_clk or posedge ARESET) begin
    if (ARESET) begin
      state_q      <= StIdle;
      pkt_count_q  <= 4'd0;
      sid_q        <= 32'd0;
      tsi_q        <= 32'd0;
      tsf_q        <= 64'd0;
      len_q        <= 16'd0;
      cnt_q        <= 16'd0;
      word_q       <= 32'd0;
      word_valid_q <= 1'b0;
      pkt_done_q   <= 1'b0;
    end else begin
      pkt_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // The presented sample is not consumed here; it becomes payload word 0.
          if (enable && s_tvalid) begin
            sid_q        <= stream_id;
            tsi_q        <= tsi;
            tsf_q        <= tsf;
            len_q        <= len_clamped;
            cnt_q        <= 16'd0;
            word_q       <= hdr_word;
            word_valid_q <= 1'b1;
            state_q      <= StHdr;
          end
        end
        StHdr: begin
          if (m_tready) begin
            word_q  <= sid_q;
            state_q <= StSid;
          end
        end
        StSid: begin
          if (m_tready) begin
            word_q  <= tsi_q;
            state_q <= StTsi;
          end
        end
        StTsi: begin
          if (m_tready) begin
            word_q  <= tsf_q[63:32];
            state_q <= StTsfHi;
          end
        end
        StTsfHi: begin
          if (m_tready) begin
            word_q  <= tsf_q[31:0];
            state_q <= StTsfLo;
          end
        end
        StTsfLo: begin
          if (m_tready) begin
            word_q       <= 32'd0;
            word_valid_q <= 1'b0;
            state_q      <= StPayload;
          end
        end
        StPayload: begin
          if (s_tvalid && m_tready) begin
            if (last_word) begin
              cnt_q       <= 16'd0;
              pkt_count_q <= pkt_count_q + 4'd1;
              pkt_done_q  <= 1'b1;
              state_q     <= StIdle;
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Payload is a combinational pass-through; everything else comes from registers.
  always_comb begin
    m_tdata  = word_q;
    m_tvalid = word_valid_q;
    m_tlast  = 1'b0;
    s_tready = 1'b0;
    if (is_payload) begin
      m_tdata  = s_tdata;
      m_tvalid = s_tvalid;
      m_tlast  = last_word;
      s_tready = m_tready;
    end
  end

  assign busy     = (state_q != StIdle);
  assign pkt_done = pkt_done_q;

endmodule

// File: tb/tb_vita49_pkt_framer.sv
module tb_vita49_pkt_framer;

  logic        samp_clk;
  logic        ARESET;
  logic        enable;
  logic [31:0] stream_id;
  logic [15:0] payload_len;
  logic [31:0] tsi;
  logic [63:0] tsf;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic        busy;
  logic        pkt_done;

  vita49_pkt_framer dut (
    .samp_clk    (samp_clk),
    .ARESET      (ARESET),
    .enable      (enable),
    .stream_id   (stream_id),
    .payload_len (payload_len),
    .tsi         (tsi),
    .tsf         (tsf),
    .s_tdata     (s_tdata),
    .s_tvalid    (s_tvalid),
    .s_tready    (s_tready),
    .m_tdata     (m_tdata),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .m_tlast     (m_tlast),
    .busy        (busy),
    .pkt_done    (pkt_done)
  );

  initial begin
    samp_clk = 1'b0;
    forever #5 samp_clk = ~samp_clk;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] sample(input int k);
    return {16'(k + 1), 16'(k + 2)};
  endfunction

  function automatic int clamp_len(input logic [15:0] l);
    if (l == 16'd0) return 1;
    if (int'(l) > 65530) return 65530;
    return int'(l);
  endfunction

  // Stimulus control shared with the driver
  int          v_pct = 100;
  int          r_pct = 100;
  bit          tsf_run = 1'b0;
  logic [63:0] tsf_hold = 64'd1000;

  // Driver: sample source obeying AXI-S hold rules, random ready, tsf counter
  initial begin
    int  drv_k;
    bit  acc;
    drv_k    = 0;
    s_tvalid = 1'b0;
    m_tready = 1'b0;
    s_tdata  = sample(0);
    tsf      = 64'd1000;
    forever begin
      @(negedge samp_clk);
      acc = s_tvalid && s_tready;
      @(posedge samp_clk);
      #1;
      if (acc) drv_k++;
      s_tdata = sample(drv_k);
      if (!(s_tvalid && !acc)) s_tvalid = ($urandom_range(99) < v_pct);
      m_tready = ($urandom_range(99) < r_pct);
      tsf      = tsf_run ? tsf + 64'd1 : tsf_hold;
    end
  end

  // Monitor results
  logic [31:0] out_q[$];
  logic [31:0] hdr_log[$];
  logic [63:0] tsf_log[$];
  logic [31:0] tsf_hi_tmp;
  int          pkt_words = 0;
  int          last_len  = 0;
  int          last_cnt  = 0;
  longint      cyc       = 0;
  longint      tlast_cyc = -10;
  longint      done_cyc  = -20;

  // Reference model: a packet is a list of words indexed by position
  bit          m_idle = 1'b1;
  int          m_pos  = 0;
  int          m_len  = 0;
  int          m_pc   = 0;
  int          m_k    = 0;
  bit          m_done = 1'b0;
  logic [31:0] m_sid, m_tsi;
  logic [63:0] m_tsf;

  // Compare process: expected outputs for this cycle, then advance across the next edge
  always @(negedge samp_clk) begin
    logic [31:0] e_data;
    logic        e_valid, e_ready, e_last;
    cyc++;
    if (ARESET) begin
      chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
      chk("rst_m_tdata", 64'(m_tdata), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_pkt_done", 64'(pkt_done), 64'd0);
      m_idle    = 1'b1;
      m_pos     = 0;
      m_pc      = 0;
      m_done    = 1'b0;
      pkt_words = 0;
    end else begin
      e_data  = 32'd0;
      e_valid = 1'b0;
      e_ready = 1'b0;
      e_last  = 1'b0;
      if (!m_idle) begin
        if (m_pos < 5) begin
          e_valid = 1'b1;
          case (m_pos)
            0: e_data = {4'h1, 4'h0, 4'h5, 4'(m_pc % 16), 16'(5 + m_len)};
            1: e_data = m_sid;
            2: e_data = m_tsi;
            3: e_data = m_tsf[63:32];
            default: e_data = m_tsf[31:0];
          endcase
        end else begin
          e_valid = s_tvalid;
          e_ready = m_tready;
          e_data  = sample(m_k);
          e_last  = (m_pos - 5 == m_len - 1);
        end
      end
      chk("busy", 64'(busy), 64'(!m_idle));
      chk("m_tvalid", 64'(m_tvalid), 64'(e_valid));
      chk("s_tready", 64'(s_tready), 64'(e_ready));
      chk("m_tlast", 64'(m_tlast), 64'(e_last));
      chk("pkt_done", 64'(pkt_done), 64'(m_done));
      if (e_valid || m_idle) chk("m_tdata", 64'(m_tdata), 64'(e_data));

      // Monitor
      if (pkt_done) done_cyc = cyc;
      if (m_tvalid && m_tready) begin
        out_q.push_back(m_tdata);
        if (pkt_words == 0) hdr_log.push_back(m_tdata);
        if (pkt_words == 3) tsf_hi_tmp = m_tdata;
        if (pkt_words == 4) tsf_log.push_back({tsf_hi_tmp, m_tdata});
        pkt_words++;
        if (m_tlast) begin
          last_len  = pkt_words;
          last_cnt++;
          tlast_cyc = cyc;
          pkt_words = 0;
        end
      end

      // Model advance
      m_done = 1'b0;
      if (m_idle) begin
        if (enable && s_tvalid) begin
          m_idle = 1'b0;
          m_pos  = 0;
          m_len  = clamp_len(payload_len);
          m_sid  = stream_id;
          m_tsi  = tsi;
          m_tsf  = tsf;
        end
      end else if (m_pos < 5) begin
        if (m_tready) m_pos++;
      end else if (s_tvalid && m_tready) begin
        m_k++;
        m_pos++;
        if (m_pos - 5 == m_len) begin
          m_idle = 1'b1;
          m_pc++;
          m_done = 1'b1;
        end
      end
    end
  end

  task automatic wait_pkts(input int n, input int budget);
    int target;
    target = last_cnt + n;
    for (int i = 0; i < budget; i++) begin
      @(posedge samp_clk);
      #1;
      if (last_cnt >= target) return;
    end
    chk("wait_pkts_timeout", 64'(last_cnt), 64'(target));
  endtask

  task automatic wait_words(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge samp_clk);
      #1;
      if (pkt_words == n) return;
    end
    chk("wait_words_timeout", 64'(pkt_words), 64'(n));
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_m_tvalid"}, 64'(m_tvalid), 64'd0);
    chk({nm, "_m_tdata"}, 64'(m_tdata), 64'd0);
    chk({nm, "_m_tlast"}, 64'(m_tlast), 64'd0);
    chk({nm, "_s_tready"}, 64'(s_tready), 64'd0);
    chk({nm, "_busy"}, 64'(busy), 64'd0);
    chk({nm, "_pkt_done"}, 64'(pkt_done), 64'd0);
  endtask

  // Reset asserted mid-cycle; outputs must clear without waiting for a clock edge
  task automatic pulse_reset(input string nm);
    #1 ARESET = 1'b1;
    #1 chk_zero(nm);
    @(posedge samp_clk);
    #2 ARESET = 1'b0;
  endtask

  logic [31:0] exp1[9];
  int          words_before;
  int          cnt_before;

  initial begin
    ARESET      = 1'b1;
    enable      = 1'b0;
    stream_id   = 32'hCAFE0001;
    payload_len = 16'd4;
    tsi         = 32'h5F000000;
    #1 chk_zero("reset");
    repeat (3) @(posedge samp_clk);
    #2 ARESET = 1'b0;

    // Basic packet with hand-computed words
    exp1 = '{32'h10500009, 32'hCAFE0001, 32'h5F000000, 32'h00000000, 32'h000003E8,
             32'h00010002, 32'h00020003, 32'h00030004, 32'h00040005};
    out_q.delete();
    @(posedge samp_clk);
    #1 enable = 1'b1;
    wait_pkts(1, 100);
    enable = 1'b0;
    chk("t1_word_count", 64'(out_q.size()), 64'd9);
    for (int i = 0; i < 9; i++) begin
      if (i < out_q.size()) chk($sformatf("t1_word%0d", i), 64'(out_q[i]), 64'(exp1[i]));
    end
    chk("t1_tlast_pos", 64'(last_len), 64'd9);
    @(posedge samp_clk);
    #1 chk("t1_done_delay", 64'(done_cyc - tlast_cyc), 64'd1);

    // 17 back-to-back packets from a fresh pkt_count
    @(posedge samp_clk);
    pulse_reset("t2_rst");
    tsf_run     = 1'b1;
    payload_len = 16'd2;
    hdr_log.delete();
    tsf_log.delete();
    enable = 1'b1;
    wait_pkts(17, 400);
    enable = 1'b0;
    chk("t2_hdr_count", 64'(hdr_log.size()), 64'd17);
    for (int i = 0; i < 17 && i < hdr_log.size(); i++) begin
      chk($sformatf("t2_hdr%0d", i), 64'(hdr_log[i]), 64'({12'h105, 4'(i % 16), 16'd7}));
      if (i > 0 && i < tsf_log.size())
        chk($sformatf("t2_tsf_incr%0d", i), 64'(tsf_log[i] > tsf_log[i-1]), 64'd1);
    end

    // Random stalls on both sides
    payload_len = 16'd7;
    v_pct = 60;
    r_pct = 50;
    enable = 1'b1;
    wait_pkts(4, 1000);
    enable = 1'b0;
    chk("t3_len", 64'(last_len), 64'd12);
    v_pct = 100;
    r_pct = 100;
    repeat (3) @(posedge samp_clk);

    // Length clamps
    hdr_log.delete();
    payload_len = 16'd0;
    #1 enable = 1'b1;
    wait_pkts(1, 100);
    enable = 1'b0;
    chk("t4_size0", 64'(hdr_log[0][15:0]), 64'd6);
    chk("t4_len0", 64'(last_len), 64'd6);
    payload_len = 16'hFFFF;
    @(posedge samp_clk);
    #1 enable = 1'b1;
    wait_pkts(1, 70000);
    enable = 1'b0;
    chk("t4_sizemax", 64'(hdr_log[hdr_log.size()-1][15:0]), 64'hFFFF);
    chk("t4_lenmax", 64'(last_len), 64'd65535);

    // Enable dropped mid-packet
    payload_len = 16'd8;
    @(posedge samp_clk);
    #1 enable = 1'b1;
    wait_words(3, 100);
    enable = 1'b0;
    wait_pkts(1, 100);
    chk("t5_len", 64'(last_len), 64'd13);
    words_before = out_q.size();
    cnt_before   = last_cnt;
    repeat (20) @(posedge samp_clk);
    #1;
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_no_words", 64'(out_q.size()), 64'(words_before));
    chk("t5_no_pkts", 64'(last_cnt), 64'(cnt_before));

    // Reset in TSI state, then in payload word 2
    payload_len = 16'd4;
    enable = 1'b1;
    wait_words(2, 100);
    pulse_reset("t6_rst_tsi");
    hdr_log.delete();
    wait_pkts(1, 100);
    chk("t6_hdr_cnt_a", 64'(hdr_log[0][19:16]), 64'd0);
    wait_words(7, 100);
    pulse_reset("t6_rst_pay");
    hdr_log.delete();
    wait_pkts(1, 100);
    enable = 1'b0;
    chk("t6_hdr_cnt_b", 64'(hdr_log[0][19:16]), 64'd0);
    repeat (3) @(posedge samp_clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
